// File: rtl/bcd_pkg.sv
// Shared BCD types, digit constants and countdown FSM state encoding.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT  = 4'd9;
  localparam bcd_digit_t BCD_ZERO_DIGIT = 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cd_state_t;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_mod_m_tick.sv
// Free-running modulo-M counter with synchronous clear and enable;
// tick is high for one cycle while the enabled count sits at M-1.
module mod_m_tick #(
  parameter int unsigned M = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = (M > 2) ? $clog2(M) : 1;
  localparam logic [W-1:0] LAST = W'(M - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/bcd_countdown.sv
// Loadable N-digit BCD countdown timer with run/stop control and done pulse.
// Optional auto-reload on completion: define BCD_COUNTDOWN_AUTORELOAD_EN.
module bcd_countdown
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  zero,
  output logic                  done_tick
);

  localparam int unsigned W = 4 * DIGITS;

  cd_state_t      state;
  logic [W-1:0]   count;
  logic [W-1:0]   reload_val;
  logic [W-1:0]   load_clamped;
  logic [W-1:0]   dec_val;
  logic [DIGITS:0] borrow;
  logic           tick;
  logic           load_zero;
  logic           dec_zero;
  logic           dn_reload;

  assign borrow[0] = 1'b1;

  // Per-digit clamp of the load value and ripple-borrow decrement of the count.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_t cur;
      assign cur                    = count[4*g +: 4];
      assign load_clamped[4*g +: 4] = bcd_clamp(load_val[4*g +: 4]);
      assign borrow[g+1]            = borrow[g] && (cur == BCD_ZERO_DIGIT);
      assign dec_val[4*g +: 4]      = !borrow[g] ? cur :
                                      (cur == BCD_ZERO_DIGIT) ? BCD_MAX_DIGIT :
                                      cur - 4'd1;
    end
  endgenerate

  assign load_zero = (load_clamped == '0);
  assign dec_zero  = (dec_val == '0);

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
  assign dn_reload = (state == DONE) && (reload_val != '0);
`else
  assign dn_reload = 1'b0;
`endif

  mod_m_tick #(
    .M (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (start | dn_reload),
    .en    (busy),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_val <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            count      <= load_clamped;
            reload_val <= load_clamped;
            state      <= load_zero ? DONE : RUN;
          end
        end
        RUN: begin
          // stop has priority over both a reload and a coincident tick
          if (stop) begin
            state <= IDLE;
          end else if (start) begin
            count      <= load_clamped;
            reload_val <= load_clamped;
            state      <= load_zero ? DONE : RUN;
          end else if (tick) begin
            count <= dec_val;
            if (dec_zero) state <= DONE;
          end
        end
        DONE: begin
          if (dn_reload) begin
            count <= reload_val;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bcd_out   = count;
  assign busy      = (state == RUN);
  assign done_tick = (state == DONE);
  assign zero      = (count == '0);

endmodule

// File: tb/tb_bcd_countdown.sv
// Scoreboard bench for bcd_countdown (DIGITS=3, TICK_DIV=4): expected output
// transitions are queued with their cycle stamp; a monitor pops on each change.
module tb_bcd_countdown;

  localparam int unsigned DIGITS   = 3;
  localparam int unsigned TICK_DIV = 4;

  typedef struct {
    int         cyc;
    logic [11:0] bcd;
    logic       busy;
    logic       done;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [11:0] load_val = '0;
  logic [11:0] bcd_out;
  logic        busy;
  logic        zero;
  logic        done_tick;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  obs_t expq[$];

  bcd_countdown #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .load_val  (load_val),
    .bcd_out   (bcd_out),
    .busy      (busy),
    .zero      (zero),
    .done_tick (done_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  task automatic push(input int c, input logic [11:0] b, input logic bs, input logic dn);
    obs_t o;
    o.cyc = c; o.bcd = b; o.busy = bs; o.done = dn;
    expq.push_back(o);
  endtask

  // Monitor: any change of the visible outputs is one observation.
  logic [13:0] prev = '0;
  always @(negedge clk) begin
    logic [13:0] now;
    obs_t o;
    now = {bcd_out, busy, done_tick};
    chk("zero_flag", int'(zero), int'(bcd_out == 12'h000));
    if (now != prev) begin
      if (expq.size() == 0) begin
        chk("unexpected_change", int'(now), int'(prev));
      end else begin
        o = expq.pop_front();
        chk("obs_cycle", cyc, o.cyc);
        chk("obs_bcd", int'(bcd_out), int'(o.bcd));
        chk("obs_busy", int'(busy), int'(o.busy));
        chk("obs_done", int'(done_tick), int'(o.done));
      end
      prev = now;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic st, input logic sp, input logic [11:0] v);
    start = st; stop = sp; load_val = v;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0;
  endtask

  // Drive so that the pulse is sampled at edge e (cyc becomes e after it).
  task automatic pulse_at(input int e, input logic st, input logic sp, input logic [11:0] v);
    if (e - 1 - cyc > 0) idle(e - 1 - cyc);
    pulse(st, sp, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d pending expected 0", expq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    #1 reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);
    chk("reset_bcd", int'(bcd_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_zero", int'(zero), 1);
    chk("reset_done", int'(done_tick), 0);

    // asynchronous reset while running at 0x057
    k = cyc + 1;
    push(k, 12'h057, 1'b1, 1'b0);
    push(k + 2, 12'h000, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 12'h057);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_bcd", int'(bcd_out), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_zero", int'(zero), 1);
    idle(2);
    reset = 1'b0;
    idle(8);

    // digit clamp on load, first tick, then stop
    k = cyc + 1;
    push(k, 12'h195, 1'b1, 1'b0);
    push(k + 4, 12'h194, 1'b1, 1'b0);
    push(k + 6, 12'h194, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 12'h1F5);
    pulse_at(k + 6, 1'b0, 1'b1, 12'h000);
    idle(6);

    // zero load completes at once; start held into DONE is ignored
    k = cyc + 1;
    push(k, 12'h000, 1'b0, 1'b1);
    push(k + 1, 12'h000, 1'b0, 1'b0);
    start = 1'b1; load_val = 12'h000;
    idle(1);
    load_val = 12'h005;
    idle(1);
    start = 1'b0;
    idle(6);

    // stop coinciding with the third tick holds 0x018
    k = cyc + 1;
    push(k, 12'h020, 1'b1, 1'b0);
    push(k + 4, 12'h019, 1'b1, 1'b0);
    push(k + 8, 12'h018, 1'b1, 1'b0);
    push(k + 12, 12'h018, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 12'h020);
    pulse_at(k + 12, 1'b0, 1'b1, 12'h000);
    idle(6);

    // simultaneous start+stop in RUN: stop wins; in IDLE: nothing loads
    k = cyc + 1;
    push(k, 12'h020, 1'b1, 1'b0);
    push(k + 4, 12'h019, 1'b1, 1'b0);
    push(k + 6, 12'h019, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 12'h020);
    pulse_at(k + 6, 1'b1, 1'b1, 12'h050);
    idle(3);
    pulse(1'b1, 1'b1, 12'h077);
    idle(8);

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    // auto-reload of 0x002: reloads after each done pulse
    k = cyc + 1;
    push(k, 12'h002, 1'b1, 1'b0);
    push(k + 4, 12'h001, 1'b1, 1'b0);
    push(k + 8, 12'h000, 1'b0, 1'b1);
    push(k + 9, 12'h002, 1'b1, 1'b0);
    push(k + 13, 12'h001, 1'b1, 1'b0);
    push(k + 17, 12'h000, 1'b0, 1'b1);
    push(k + 18, 12'h002, 1'b1, 1'b0);
    push(k + 20, 12'h002, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 12'h002);
    pulse_at(k + 20, 1'b0, 1'b1, 12'h000);
    idle(8);
`else
    // full countdown from 0x103 through the 0x100 -> 0x099 borrow
    k = cyc + 1;
    push(k, 12'h103, 1'b1, 1'b0);
    for (int n = 1; n < 103; n++) push(k + 4 * n, to_bcd(103 - n), 1'b1, 1'b0);
    push(k + 412, 12'h000, 1'b0, 1'b1);
    push(k + 413, 12'h000, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 12'h103);
    idle(420);
    chk("idle_after_done_bcd", int'(bcd_out), 0);
    chk("idle_after_done_busy", int'(busy), 0);

    // start in RUN reloads and restarts the prescaler
    k = cyc + 1;
    push(k, 12'h005, 1'b1, 1'b0);
    push(k + 4, 12'h004, 1'b1, 1'b0);
    push(k + 6, 12'h003, 1'b1, 1'b0);
    push(k + 10, 12'h002, 1'b1, 1'b0);
    push(k + 14, 12'h001, 1'b1, 1'b0);
    push(k + 18, 12'h000, 1'b0, 1'b1);
    push(k + 19, 12'h000, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 12'h005);
    pulse_at(k + 6, 1'b1, 1'b0, 12'h003);
    idle(25);
`endif

    chk("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
